// File: rtl/axi_mem_model.sv
// AXI-style slave line memory: programmable read latency, in-order outstanding reads, B responses.
// Define AXI_MEM_WSTRB_EN to add wstrb_i and byte-masked commits.
module axi_mem_model #(
  parameter int unsigned ID_W       = 16,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 576,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned LINE_SHIFT = 6,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned RD_OUTST   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ID_W-1:0]   wid_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef AXI_MEM_WSTRB_EN
  input  logic [DATA_W/8-1:0] wstrb_i,
`endif
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic              bvalid_o,
  input  logic              bready_i
);

  localparam int unsigned DEPTH  = 1 << IDX_W;
  localparam int unsigned PTR_W  = (RD_OUTST > 1) ? $clog2(RD_OUTST) : 1;
  localparam int unsigned CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned CNTR_W = $clog2(RD_OUTST + 1);
  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ID_W-1:0]   r_q_id   [RD_OUTST];
  logic [DATA_W-1:0] r_q_data [RD_OUTST];
  logic [CNT_W-1:0]  r_q_cnt  [RD_OUTST];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNTR_W-1:0] r_count;

  logic              r_aw_full, r_w_full, r_bvalid;
  logic [ID_W-1:0]   r_aw_id, r_bid;
  logic [IDX_W-1:0]  r_aw_idx;
  logic [DATA_W-1:0] r_w_data;

  logic              w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_commit;
  logic [IDX_W-1:0]  w_ar_idx, w_aw_idx;
  logic [ID_W-1:0]   w_aw_id;
  logic [DATA_W-1:0] w_wd, w_line, w_ar_line;
  logic              w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RD_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign arready_o = (r_count < CNTR_W'(RD_OUTST));
  assign rvalid_o  = (r_count != '0) && (r_q_cnt[r_head] == '0);
  assign rid_o     = r_q_id[r_head];
  assign rdata_o   = r_q_data[r_head];
  assign w_ar_hs   = arvalid_i & arready_o;
  assign w_r_hs    = rvalid_o & rready_i;
  assign w_ar_idx  = araddr_i[LINE_SHIFT +: IDX_W];

  assign awready_o = !r_aw_full;
  assign wready_o  = !r_w_full;
  assign bvalid_o  = r_bvalid;
  assign bid_o     = r_bid;
  assign w_aw_hs   = awvalid_i & awready_o;
  assign w_w_hs    = wvalid_i & wready_o;

  // A channel handshaking this cycle counts as already held, so B can follow the later handshake by one cycle.
  assign w_aw_id   = r_aw_full ? r_aw_id  : awid_i;
  assign w_aw_idx  = r_aw_full ? r_aw_idx : awaddr_i[LINE_SHIFT +: IDX_W];
  assign w_wd      = r_w_full  ? r_w_data : wdata_i;
  assign w_commit  = rst_n & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & (!r_bvalid | bready_i);

`ifdef AXI_MEM_WSTRB_EN
  logic [NBYTES-1:0] r_w_strb;
  logic [NBYTES-1:0] w_strb;
  logic [DATA_W-1:0] w_old;
  assign w_strb = r_w_full ? r_w_strb : wstrb_i;
  assign w_old  = mem[w_aw_idx];
  for (genvar g = 0; g < NBYTES; g++) begin : g_merge
    assign w_line[g*8 +: 8] = w_strb[g] ? w_wd[g*8 +: 8] : w_old[g*8 +: 8];
  end
`else
  assign w_line = w_wd;
`endif

  assign w_ar_line = (w_commit && (w_aw_idx == w_ar_idx)) ? w_line : mem[w_ar_idx];
  assign w_unused  = ^{wid_i, araddr_i, awaddr_i};

  always_ff @(posedge clk) begin
    if (w_commit) mem[w_aw_idx] <= w_line;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < RD_OUTST; i++) begin
        r_q_id[PTR_W'(i)]   <= '0;
        r_q_data[PTR_W'(i)] <= '0;
        r_q_cnt[PTR_W'(i)]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RD_OUTST; i++) begin
        if (r_q_cnt[PTR_W'(i)] != '0) r_q_cnt[PTR_W'(i)] <= r_q_cnt[PTR_W'(i)] - CNT_W'(1);
      end
      if (w_ar_hs) begin
        r_q_id[r_tail]   <= arid_i;
        r_q_data[r_tail] <= w_ar_line;
        r_q_cnt[r_tail]  <= CNT_W'(RD_LAT - 1);
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_r_hs) r_head <= ptr_inc(r_head);
      case ({w_ar_hs, w_r_hs})
        2'b10:   r_count <= r_count + CNTR_W'(1);
        2'b01:   r_count <= r_count - CNTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_id   <= '0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
`ifdef AXI_MEM_WSTRB_EN
      r_w_strb  <= '0;
`endif
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bid     <= w_aw_id;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_id   <= awid_i;
        r_aw_idx  <= awaddr_i[LINE_SHIFT +: IDX_W];
      end
      if (w_w_hs) begin
        r_w_full  <= 1'b1;
        r_w_data  <= wdata_i;
`ifdef AXI_MEM_WSTRB_EN
        r_w_strb  <= wstrb_i;
`endif
      end
      if (r_bvalid && bready_i) r_bvalid <= 1'b0;
    end
  end

  task automatic backdoor_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] line);
    mem[idx] <= line;
  endtask

  function automatic logic [DATA_W-1:0] backdoor_read(input logic [IDX_W-1:0] idx);
    return mem[idx];
  endfunction

endmodule

// File: tb/tb_axi_mem_model.sv
// Directed self-checking bench for axi_mem_model: latency, ordering, B channel, bypass, reset.
module tb_axi_mem_model;
  localparam int unsigned ID_W = 16, ADDR_W = 64, DATA_W = 576, IDX_W = 10;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [ID_W-1:0]   arid_i = '0, awid_i = '0, wid_i = '0;
  logic [ADDR_W-1:0] araddr_i = '0, awaddr_i = '0;
  logic              arvalid_i = 1'b0, rready_i = 1'b0, awvalid_i = 1'b0, wvalid_i = 1'b0, bready_i = 1'b0;
  logic [DATA_W-1:0] wdata_i = '0;
`ifdef AXI_MEM_WSTRB_EN
  logic [DATA_W/8-1:0] wstrb_i = '1;
`endif
  logic              arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [ID_W-1:0]   rid_o, bid_o;
  logic [DATA_W-1:0] rdata_o;

  int n_assert = 0, n_fail = 0;

  localparam logic [DATA_W-1:0] L1 = {64'hc0000003c0000000, {512{1'b1}}};
  localparam logic [DATA_W-1:0] LD = {72{8'hdd}};
  localparam logic [DATA_W-1:0] LE = {72{8'hee}};
  localparam logic [DATA_W-1:0] LN = {64'h123456789abcdef0, {8{64'h0123456789abcdef}}};

  axi_mem_model #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
                  .LINE_SHIFT(6), .RD_LAT(4), .RD_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i),
`ifdef AXI_MEM_WSTRB_EN
    .wstrb_i(wstrb_i),
`endif
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] pat(input int unsigned k);
    return {64'hA000 + 64'(k), {8{64'(k) + 64'h5a00}}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drops arvalid once the edge just taken accepted the request.
  task automatic tick_ar();
    logic hs;
    hs = arvalid_i && arready_o;
    @(posedge clk); #1;
    if (hs) arvalid_i = 1'b0;
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (rvalid_o) begin ok = 1'b1; break; end
      tick_ar();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_assert++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b exp 0", rvalid_o); end
    n_assert++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got %0b exp 0", bvalid_o); end
    n_assert++; if (arready_o !== 1'b1) begin n_fail++; $display("FAIL reset_arready got %0b exp 1", arready_o); end
    n_assert++; if (awready_o !== 1'b1) begin n_fail++; $display("FAIL reset_awready got %0b exp 1", awready_o); end
    n_assert++; if (wready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %0b exp 1", wready_o); end
    n_assert++; if (rid_o !== '0) begin n_fail++; $display("FAIL reset_rid got %0h exp 0", rid_o); end
    n_assert++; if (bid_o !== '0) begin n_fail++; $display("FAIL reset_bid got %0h exp 0", bid_o); end
    n_assert++; if (rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata got %0h exp 0", rdata_o); end
  endtask

  task automatic test_read_latency();
    dut.backdoor_write(10'd1, L1);
    tick();
    arid_i = 16'd3; araddr_i = 64'h0000000f00000040; arvalid_i = 1'b1;
    tick_ar();
    for (int i = 0; i < 3; i++) begin
      n_assert++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL lat_early cycle %0d got %0b exp 0", i + 1, rvalid_o); end
      tick();
    end
    n_assert++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL lat_rvalid got %0b exp 1", rvalid_o); end
    n_assert++; if (rid_o !== 16'd3) begin n_fail++; $display("FAIL lat_rid got %0h exp 3", rid_o); end
    n_assert++; if (rdata_o !== L1) begin n_fail++; $display("FAIL lat_rdata got %0h exp %0h", rdata_o, L1); end
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    n_assert++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL lat_pop got %0b exp 0", rvalid_o); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int unsigned k = 0; k < 5; k++) dut.backdoor_write(IDX_W'(10 + k), pat(k));
    tick();
    rready_i = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      arid_i = ID_W'(k); araddr_i = 64'(10 + k) << 6; arvalid_i = 1'b1;
      tick_ar();
    end
    n_assert++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full_arready got %0b exp 0", arready_o); end
    arid_i = 16'd4; araddr_i = 64'd14 << 6; arvalid_i = 1'b1;
    repeat (3) tick_ar();
    n_assert++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_rvalid got %0b exp 1", rvalid_o); end
    n_assert++; if (rid_o !== 16'd0) begin n_fail++; $display("FAIL b2b_hold_rid got %0h exp 0", rid_o); end
    rready_i = 1'b1;
    n_assert++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_arready got %0b exp 0", arready_o); end
    for (int unsigned k = 0; k < 5; k++) begin
      wait_rvalid(ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout resp %0d got no rvalid exp rvalid", k); end
      n_assert++; if (rid_o !== ID_W'(k)) begin n_fail++; $display("FAIL b2b_rid resp %0d got %0h exp %0h", k, rid_o, k); end
      n_assert++; if (rdata_o !== pat(k)) begin n_fail++; $display("FAIL b2b_rdata resp %0d got %0h exp %0h", k, rdata_o, pat(k)); end
      tick_ar();
    end
    rready_i = 1'b0;
    arvalid_i = 1'b0;
  endtask

  task automatic test_write_b();
    bready_i = 1'b0;
    awid_i = 16'd7; awaddr_i = 64'h40; awvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0;
    n_assert++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_aw_only_bvalid got %0b exp 0", bvalid_o); end
    n_assert++; if (awready_o !== 1'b0) begin n_fail++; $display("FAIL wr_aw_held_awready got %0b exp 0", awready_o); end
    tick();
    n_assert++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_c2_bvalid got %0b exp 0", bvalid_o); end
    wdata_i = LD; wvalid_i = 1'b1;
    tick();
    wvalid_i = 1'b0;
    n_assert++; if (bvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_c3_bvalid got %0b exp 1", bvalid_o); end
    n_assert++; if (bid_o !== 16'd7) begin n_fail++; $display("FAIL wr_c3_bid got %0h exp 7", bid_o); end
    n_assert++; if (awready_o !== 1'b1 || wready_o !== 1'b1) begin n_fail++; $display("FAIL wr_freed got aw%0b w%0b exp aw1 w1", awready_o, wready_o); end
    awid_i = 16'd9; awaddr_i = 64'h80; awvalid_i = 1'b1; wdata_i = LE; wvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    n_assert++; if (awready_o !== 1'b0 || wready_o !== 1'b0) begin n_fail++; $display("FAIL wr_held2 got aw%0b w%0b exp aw0 w0", awready_o, wready_o); end
    for (int i = 0; i < 2; i++) begin
      n_assert++; if (bvalid_o !== 1'b1 || bid_o !== 16'd7) begin n_fail++; $display("FAIL wr_bhold got bvalid %0b bid %0h exp 1 7", bvalid_o, bid_o); end
      tick();
    end
    n_assert++; if (bvalid_o !== 1'b1 || bid_o !== 16'd7) begin n_fail++; $display("FAIL wr_bhold3 got bvalid %0b bid %0h exp 1 7", bvalid_o, bid_o); end
    bready_i = 1'b1;
    tick();
    n_assert++; if (bvalid_o !== 1'b1 || bid_o !== 16'd9) begin n_fail++; $display("FAIL wr_second_b got bvalid %0b bid %0h exp 1 9", bvalid_o, bid_o); end
    tick();
    n_assert++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_b_drain got %0b exp 0", bvalid_o); end
    bready_i = 1'b0;
    n_assert++; if (dut.backdoor_read(10'd1) !== LD) begin n_fail++; $display("FAIL wr_mem1 got %0h exp %0h", dut.backdoor_read(10'd1), LD); end
    n_assert++; if (dut.backdoor_read(10'd2) !== LE) begin n_fail++; $display("FAIL wr_mem2 got %0h exp %0h", dut.backdoor_read(10'd2), LE); end
  endtask

  task automatic test_collision();
    bit ok;
    logic [DATA_W-1:0] exp;
`ifdef AXI_MEM_WSTRB_EN
    exp = LE;
    exp[7:0] = LN[7:0];
    wstrb_i = '0;
    wstrb_i[0] = 1'b1;
`else
    exp = LN;
`endif
    bready_i = 1'b1;
    awid_i = 16'd5; awaddr_i = 64'h80; awvalid_i = 1'b1; wdata_i = LN; wvalid_i = 1'b1;
    arid_i = 16'd6; araddr_i = 64'h0000000000010080; arvalid_i = 1'b1;
    tick_ar();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
`ifdef AXI_MEM_WSTRB_EN
    wstrb_i = '1;
`endif
    n_assert++; if (bvalid_o !== 1'b1 || bid_o !== 16'd5) begin n_fail++; $display("FAIL col_b got bvalid %0b bid %0h exp 1 5", bvalid_o, bid_o); end
    wait_rvalid(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL col_timeout got no rvalid exp rvalid"); end
    n_assert++; if (rid_o !== 16'd6) begin n_fail++; $display("FAIL col_rid got %0h exp 6", rid_o); end
    n_assert++; if (rdata_o !== exp) begin n_fail++; $display("FAIL col_rdata got %0h exp %0h", rdata_o, exp); end
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0; bready_i = 1'b0;
    n_assert++; if (dut.backdoor_read(10'd2) !== exp) begin n_fail++; $display("FAIL col_mem got %0h exp %0h", dut.backdoor_read(10'd2), exp); end
  endtask

  task automatic test_reset_midflight();
    arid_i = 16'd1; araddr_i = 64'h40; arvalid_i = 1'b1;
    tick_ar();
    arid_i = 16'd2; araddr_i = 64'h80; arvalid_i = 1'b1;
    tick_ar();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    rready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_assert++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid cycle %0d got %0b exp 0", i, rvalid_o); end
      tick();
    end
    rready_i = 1'b0;
    n_assert++; if (arready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_arready got %0b exp 1", arready_o); end
    n_assert++; if (rid_o !== '0) begin n_fail++; $display("FAIL rst_mid_rid got %0h exp 0", rid_o); end
    n_assert++; if (dut.backdoor_read(10'd1) !== LD) begin n_fail++; $display("FAIL rst_mid_mem_kept got %0h exp %0h", dut.backdoor_read(10'd1), LD); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_write_b();
    test_collision();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
